instrumented_adder_sweeper: RTL and testbench

Parametrised measurement sequencer for the instrumented adder ring. It steps the ring-oscillator tap through a range of adder bit positions. For each position it counts ring edges over a programmable window of `wb_clk_i` cycles and hands each (bit, count) result out over a valid/ready port. It sits between the logic-analyser control registers and the instrumented adder, and replaces manual one-bit-at-a-time firmware sweeps.

---
 rtl/instrumented_adder_sweeper.sv | 203 ++++++++++++++++++++
 tb/tb_instrumented_adder_sweeper.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/instrumented_adder_sweeper.sv
// rtl/instrumented_adder_sweeper.sv - ring-oscillator tap sweeper with windowed edge counting
// Optional extrema tracking under INSTR_ADDER_SWEEP_MINMAX_EN.
module instrumented_adder_sweeper #(
   parameter int WIDTH    = 32,
   parameter int WINDOW_W = 16,
   parameter int COUNT_W  = 24,
   parameter int SEL_W    = $clog2(WIDTH)
) (
   input  logic                wb_clk_i,
   input  logic                rst_n,
   input  logic                start,
   input  logic                abort,
   input  logic [SEL_W-1:0]    first_bit,
   input  logic [SEL_W-1:0]    last_bit,
   input  logic [WINDOW_W-1:0] window,
   output logic                ring_en,
   output logic [WIDTH-1:0]    ring_sel,
   input  logic                chain_out,
   output logic                res_valid,
   input  logic                res_ready,
   output logic [SEL_W-1:0]    res_bit,
   output logic [COUNT_W-1:0]  res_count,
   output logic                busy,
   output logic                done,
   output logic [COUNT_W-1:0]  min_count,
   output logic [COUNT_W-1:0]  max_count,
   output logic [SEL_W-1:0]    min_bit
);

   typedef enum logic [2:0] {S_IDLE, S_ARM, S_MEASURE, S_EMIT, S_NEXT} state_t;

   state_t              state_q;
   logic [SEL_W-1:0]    cur_bit_q, last_bit_q;
   logic [WINDOW_W-1:0] window_q, win_cnt_q;
   logic                single_q;
   logic [1:0]          arm_cnt_q;
   logic [COUNT_W-1:0]  count_q;
   logic                sync1_q, sync2_q, sync3_q;
   logic                ring_en_q, res_valid_q, busy_q, done_q;
   logic [WIDTH-1:0]    ring_sel_q;
   logic [SEL_W-1:0]    res_bit_q;
   logic [COUNT_W-1:0]  res_count_q;

   logic                edge_det;
   logic [COUNT_W-1:0]  count_d;
   logic [SEL_W-1:0]    next_bit_d;
   logic                final_d;
   logic                handshake;

   function automatic logic [WIDTH-1:0] onehot(input logic [SEL_W-1:0] b);
      logic [WIDTH-1:0] v;
      v    = '0;
      v[b] = 1'b1;
      return v;
   endfunction

   // sync3_q is the previous synchronised sample, so edge_det is a rising edge of chain_out
   assign edge_det   = sync2_q & ~sync3_q;
   assign count_d    = (edge_det && (count_q != {COUNT_W{1'b1}})) ? count_q + 1'b1 : count_q;
   assign next_bit_d = cur_bit_q + 1'b1;
   assign final_d    = single_q || (cur_bit_q == last_bit_q);
   assign handshake  = (state_q == S_EMIT) && res_ready && !abort;

   always_ff @(posedge wb_clk_i or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         sync3_q <= 1'b0;
      end else begin
         sync1_q <= chain_out;
         sync2_q <= sync1_q;
         sync3_q <= sync2_q;
      end
   end

   always_ff @(posedge wb_clk_i or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         cur_bit_q   <= '0;
         last_bit_q  <= '0;
         window_q    <= '0;
         win_cnt_q   <= '0;
         single_q    <= 1'b0;
         arm_cnt_q   <= '0;
         count_q     <= '0;
         ring_en_q   <= 1'b0;
         ring_sel_q  <= '0;
         res_valid_q <= 1'b0;
         res_bit_q   <= '0;
         res_count_q <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         done_q <= 1'b0;
         if (abort) begin
            state_q     <= S_IDLE;
            ring_en_q   <= 1'b0;
            ring_sel_q  <= '0;
            res_valid_q <= 1'b0;
            busy_q      <= 1'b0;
         end else begin
            case (state_q)
               S_IDLE: if (start) begin
                  cur_bit_q  <= first_bit;
                  last_bit_q <= last_bit;
                  window_q   <= (window == '0) ? WINDOW_W'(1) : window;
                  single_q   <= (first_bit > last_bit);
                  arm_cnt_q  <= '0;
                  ring_en_q  <= 1'b1;
                  ring_sel_q <= onehot(first_bit);
                  busy_q     <= 1'b1;
                  state_q    <= S_ARM;
               end
               S_ARM: begin
                  if (arm_cnt_q == 2'd3) begin
                     count_q   <= '0;
                     win_cnt_q <= window_q;
                     state_q   <= S_MEASURE;
                  end else begin
                     arm_cnt_q <= arm_cnt_q + 1'b1;
                  end
               end
               S_MEASURE: begin
                  count_q <= count_d;
                  if (win_cnt_q == WINDOW_W'(1)) begin
                     res_count_q <= count_d;
                     res_bit_q   <= cur_bit_q;
                     res_valid_q <= 1'b1;
                     ring_en_q   <= 1'b0;
                     ring_sel_q  <= '0;
                     state_q     <= S_EMIT;
                  end else begin
                     win_cnt_q <= win_cnt_q - 1'b1;
                  end
               end
               S_EMIT: if (res_ready) begin
                  res_valid_q <= 1'b0;
                  done_q      <= final_d;
                  state_q     <= S_NEXT;
               end
               S_NEXT: begin
                  if (final_d) begin
                     busy_q  <= 1'b0;
                     state_q <= S_IDLE;
                  end else begin
                     cur_bit_q  <= next_bit_d;
                     arm_cnt_q  <= '0;
                     ring_en_q  <= 1'b1;
                     ring_sel_q <= onehot(next_bit_d);
                     state_q    <= S_ARM;
                  end
               end
               default: state_q <= S_IDLE;
            endcase
         end
      end
   end

   assign ring_en   = ring_en_q;
   assign ring_sel  = ring_sel_q;
   assign res_valid = res_valid_q;
   assign res_bit   = res_bit_q;
   assign res_count = res_count_q;
   assign busy      = busy_q;
   assign done      = done_q;

`ifdef INSTR_ADDER_SWEEP_MINMAX_EN
   logic [COUNT_W-1:0] min_q, max_q;
   logic [SEL_W-1:0]   min_bit_q;
   logic               have_q;

   // Taps ascend within a sweep, so a strict compare keeps the lower index on ties
   always_ff @(posedge wb_clk_i or negedge rst_n) begin
      if (!rst_n) begin
         min_q     <= '0;
         max_q     <= '0;
         min_bit_q <= '0;
         have_q    <= 1'b0;
      end else if ((state_q == S_IDLE) && start && !abort) begin
         min_q     <= {COUNT_W{1'b1}};
         max_q     <= '0;
         min_bit_q <= '0;
         have_q    <= 1'b0;
      end else if (handshake) begin
         have_q <= 1'b1;
         if (!have_q || (res_count_q < min_q)) begin
            min_q     <= res_count_q;
            min_bit_q <= res_bit_q;
         end
         if (res_count_q > max_q) max_q <= res_count_q;
      end
   end

   assign min_count = min_q;
   assign max_count = max_q;
   assign min_bit   = min_bit_q;
`else
   assign min_count = '0;
   assign max_count = '0;
   assign min_bit   = '0;
`endif

endmodule

// File: tb/tb_instrumented_adder_sweeper.sv
// tb/tb_instrumented_adder_sweeper.sv - directed self-checking bench for instrumented_adder_sweeper
module tb_instrumented_adder_sweeper;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0, abort = 1'b0, res_ready = 1'b1, chain_out = 1'b0;
   logic [4:0]  first_bit = '0, last_bit = '0;
   logic [15:0] window = '0;
   logic        ring_en, res_valid, busy, done;
   logic [31:0] ring_sel;
   logic [4:0]  res_bit, min_bit;
   logic [23:0] res_count, min_count, max_count;

   logic        s_start = 1'b0, s_chain = 1'b0;
   logic [2:0]  s_first = '0, s_last = '0;
   logic [15:0] s_window = '0;
   logic        s_ring_en, s_res_valid, s_busy, s_done;
   logic [7:0]  s_ring_sel;
   logic [2:0]  s_res_bit, s_min_bit;
   logic [3:0]  s_res_count, s_min_count, s_max_count;

   int errors = 0, checks = 0, ph = 0;

   logic [31:0] sels[8];
   logic [4:0]  rbits[8];
   logic [23:0] rcnts[8];
   int          ridx[8];
   int          nr, ns, ndone, done_idx, en_fall0;
   logic        sel_bad, timed_out;

   always #5 clk = ~clk;

   instrumented_adder_sweeper dut (
      .wb_clk_i(clk), .rst_n(rst_n), .start(start), .abort(abort),
      .first_bit(first_bit), .last_bit(last_bit), .window(window),
      .ring_en(ring_en), .ring_sel(ring_sel), .chain_out(chain_out),
      .res_valid(res_valid), .res_ready(res_ready), .res_bit(res_bit), .res_count(res_count),
      .busy(busy), .done(done), .min_count(min_count), .max_count(max_count), .min_bit(min_bit)
   );

   instrumented_adder_sweeper #(.WIDTH(8), .COUNT_W(4)) dut_sat (
      .wb_clk_i(clk), .rst_n(rst_n), .start(s_start), .abort(1'b0),
      .first_bit(s_first), .last_bit(s_last), .window(s_window),
      .ring_en(s_ring_en), .ring_sel(s_ring_sel), .chain_out(s_chain),
      .res_valid(s_res_valid), .res_ready(1'b1), .res_bit(s_res_bit), .res_count(s_res_count),
      .busy(s_busy), .done(s_done), .min_count(s_min_count), .max_count(s_max_count), .min_bit(s_min_bit)
   );

   // Taps 1 and 2 ring with a 6-clock period, every other tap with a 4-clock period
   always @(negedge clk) begin
      ph++;
      if (ring_sel[1] | ring_sel[2]) chain_out = (ph % 6) < 3;
      else                           chain_out = (ph % 4) < 2;
      s_chain = (ph % 4) < 2;
   end

   task automatic do_start(input logic [4:0] f, input logic [4:0] l, input logic [15:0] w);
      @(negedge clk);
      first_bit = f; last_bit = l; window = w; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic run_sweep(input int max_cyc);
      int   i;
      logic prev_en;
      nr = 0; ns = 0; ndone = 0; done_idx = 0; en_fall0 = 0;
      sel_bad = 1'b0; timed_out = 1'b1; prev_en = 1'b0; i = 1;
      while (i <= max_cyc) begin
         if (ring_en && !prev_en && ns < 8) begin sels[ns] = ring_sel; ns++; end
         if (!ring_en && prev_en && en_fall0 == 0) en_fall0 = i;
         if (!ring_en && ring_sel != 32'h0) sel_bad = 1'b1;
         if (res_valid && res_ready && nr < 8) begin
            rbits[nr] = res_bit; rcnts[nr] = res_count; ridx[nr] = i; nr++;
         end
         if (done) begin ndone++; done_idx = i; end
         prev_en = ring_en;
         if (!busy) begin timed_out = 1'b0; break; end
         @(negedge clk);
         i++;
      end
   endtask

   task automatic test_reset();
      logic bad;
      repeat (3) @(negedge clk);
      checks++;
      if ({ring_en, ring_sel, res_valid, res_bit, res_count, busy, done, min_count, max_count, min_bit} !== '0) begin
         errors++; $display("FAIL reset_outputs: got nonzero outputs in reset, want all 0");
      end
      rst_n = 1'b1;
      bad = 1'b0;
      repeat (30) begin
         @(negedge clk);
         if (ring_en || busy || res_valid || done || ring_sel != 0) bad = 1'b1;
      end
      checks++;
      if (bad !== 1'b0) begin errors++; $display("FAIL idle_quiet: got activity=%0b want 0", bad); end
   endtask

   task automatic test_sweep();
      res_ready = 1'b1;
      do_start(5'd3, 5'd5, 16'd100);
      checks++;
      if (ring_en !== 1'b1 || ring_sel !== 32'h08) begin
         errors++; $display("FAIL arm_entry: got en=%0b sel=%h want en=1 sel=00000008", ring_en, ring_sel);
      end
      run_sweep(600);
      checks++;
      if (timed_out || nr !== 3) begin errors++; $display("FAIL sweep_results: got %0d results timeout=%0b want 3", nr, timed_out); end
      for (int k = 0; k < 3; k++) begin
         checks++;
         if (rbits[k] !== 5'(3 + k) || rcnts[k] < 24 || rcnts[k] > 25) begin
            errors++; $display("FAIL sweep_result%0d: got bit=%0d count=%0d want bit=%0d count 24..25", k, rbits[k], rcnts[k], 3 + k);
         end
         checks++;
         if (sels[k] !== (32'h08 << k)) begin
            errors++; $display("FAIL sweep_sel%0d: got %h want %h", k, sels[k], 32'h08 << k);
         end
      end
      checks++;
      if (ridx[0] !== 105 || en_fall0 !== 105) begin
         errors++; $display("FAIL first_latency: got valid@%0d en_fall@%0d want 105 and 105", ridx[0], en_fall0);
      end
      checks++;
      if (ndone !== 1 || done_idx !== ridx[2] + 1) begin
         errors++; $display("FAIL sweep_done: got pulses=%0d at %0d want 1 at %0d", ndone, done_idx, ridx[2] + 1);
      end
      checks++;
      if (sel_bad !== 1'b0) begin errors++; $display("FAIL sel_when_disabled: got nonzero ring_sel with ring_en=0 want 0"); end
   endtask

   task automatic test_hold();
      logic [4:0]  b;
      logic [23:0] c;
      logic        bad;
      int          n;
      res_ready = 1'b0;
      do_start(5'd6, 5'd6, 16'd8);
      n = 0;
      while (!res_valid && n < 50) begin @(negedge clk); n++; end
      b = res_bit; c = res_count;
      checks++;
      if (res_valid !== 1'b1 || b !== 5'd6 || c !== 24'd2) begin
         errors++; $display("FAIL hold_result: got valid=%0b bit=%0d count=%0d want 1 6 2", res_valid, b, c);
      end
      bad = 1'b0;
      repeat (10) begin
         @(negedge clk);
         if (res_valid !== 1'b1 || res_bit !== b || res_count !== c || done !== 1'b0) bad = 1'b1;
      end
      checks++;
      if (bad !== 1'b0) begin errors++; $display("FAIL hold_stable: got change while stalled want stable"); end
      res_ready = 1'b1;
      @(negedge clk);
      checks++;
      if (res_valid !== 1'b0 || busy !== 1'b1 || done !== 1'b1) begin
         errors++; $display("FAIL hold_release: got valid=%0b busy=%0b done=%0b want 0 1 1", res_valid, busy, done);
      end
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || done !== 1'b0) begin
         errors++; $display("FAIL hold_idle: got busy=%0b done=%0b want 0 0", busy, done);
      end
   endtask

   task automatic test_window0_single();
      res_ready = 1'b1;
      do_start(5'd5, 5'd3, 16'd0);
      run_sweep(100);
      checks++;
      if (timed_out || nr !== 1 || rbits[0] !== 5'd5 || rcnts[0] > 1) begin
         errors++; $display("FAIL single_w0: got n=%0d bit=%0d count=%0d want 1 result bit 5 count<=1", nr, rbits[0], rcnts[0]);
      end
      checks++;
      if (ridx[0] !== 6 || ndone !== 1) begin
         errors++; $display("FAIL w0_latency: got valid@%0d done=%0d want 6 and 1", ridx[0], ndone);
      end
   endtask

   task automatic test_saturate();
      int n;
      @(negedge clk);
      s_first = 3'd0; s_last = 3'd0; s_window = 16'd160; s_start = 1'b1;
      @(negedge clk);
      s_start = 1'b0;
      n = 0;
      while (!s_res_valid && n < 300) begin @(negedge clk); n++; end
      checks++;
      if (s_res_valid !== 1'b1 || s_res_count !== 4'd15 || s_res_bit !== 3'd0) begin
         errors++; $display("FAIL saturate: got valid=%0b count=%0d bit=%0d want 1 15 0", s_res_valid, s_res_count, s_res_bit);
      end
   endtask

   task automatic test_abort();
      logic bad;
      res_ready = 1'b1;
      do_start(5'd7, 5'd9, 16'd50);
      repeat (10) @(negedge clk);
      checks++;
      if (busy !== 1'b1 || ring_en !== 1'b1 || ring_sel !== 32'h80) begin
         errors++; $display("FAIL abort_pre: got busy=%0b en=%0b sel=%h want 1 1 00000080", busy, ring_en, ring_sel);
      end
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      checks++;
      if (ring_en !== 1'b0 || busy !== 1'b0 || ring_sel !== 32'h0 || res_valid !== 1'b0) begin
         errors++; $display("FAIL abort_clear: got en=%0b busy=%0b sel=%h valid=%0b want all 0", ring_en, busy, ring_sel, res_valid);
      end
      bad = 1'b0;
      repeat (120) begin
         @(negedge clk);
         if (res_valid || done || busy) bad = 1'b1;
      end
      checks++;
      if (bad !== 1'b0) begin errors++; $display("FAIL abort_silent: got result/done after abort want none"); end
      do_start(5'd0, 5'd0, 16'd20);
      run_sweep(100);
      checks++;
      if (timed_out || nr !== 1 || rbits[0] !== 5'd0 || rcnts[0] !== 24'd5 || ndone !== 1) begin
         errors++; $display("FAIL abort_restart: got n=%0d bit=%0d count=%0d done=%0d want 1 0 5 1", nr, rbits[0], rcnts[0], ndone);
      end
   endtask

   task automatic test_async_reset();
      do_start(5'd4, 5'd4, 16'd40);
      repeat (8) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if (ring_en !== 1'b0 || busy !== 1'b0 || ring_sel !== 32'h0) begin
         errors++; $display("FAIL async_reset: got en=%0b busy=%0b sel=%h want 0 0 0", ring_en, busy, ring_sel);
      end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_minmax();
      res_ready = 1'b1;
      do_start(5'd0, 5'd2, 16'd120);
      run_sweep(600);
      checks++;
      if (timed_out || nr !== 3 || rcnts[0] !== 24'd30 || rcnts[1] !== 24'd20 || rcnts[2] !== 24'd20) begin
         errors++; $display("FAIL mm_counts: got n=%0d %0d/%0d/%0d want 3 30/20/20", nr, rcnts[0], rcnts[1], rcnts[2]);
      end
      repeat (5) @(negedge clk);
`ifdef INSTR_ADDER_SWEEP_MINMAX_EN
      checks++;
      if (min_count !== 24'd20 || min_bit !== 5'd1 || max_count !== 24'd30) begin
         errors++; $display("FAIL minmax: got min=%0d bit=%0d max=%0d want 20 1 30", min_count, min_bit, max_count);
      end
`else
      checks++;
      if (min_count !== 24'd0 || min_bit !== 5'd0 || max_count !== 24'd0) begin
         errors++; $display("FAIL minmax_tied: got min=%0d bit=%0d max=%0d want 0 0 0", min_count, min_bit, max_count);
      end
`endif
   endtask

   initial begin
      test_reset();
      test_sweep();
      test_hold();
      test_window0_single();
      test_saturate();
      test_abort();
      test_async_reset();
      test_minmax();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
